// File: rtl/sram_stream_reader_if.sv
// Signal bundle for sram_stream_reader: command/status, SRAM s2 read port and output stream.
// The master modport is the reader's view; the slave modport is the controller/SRAM/sink view.
interface sram_stream_reader_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 16
);
    // Command and status
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [12:0]           length;
    logic                  busy;
    logic                  done;

    // SRAM s2 Avalon-MM port
    logic [ADDR_WIDTH-1:0] address;
    logic                  chipselect;
    logic                  write;
    logic [1:0]            byteenable;
    logic [DATA_WIDTH-1:0] writedata;
    logic [DATA_WIDTH-1:0] readdata;

    // Avalon-ST output
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        input  start, base_addr, length, readdata, out_ready,
        output busy, done, address, chipselect, write, byteenable, writedata,
        output out_data, out_valid
    );

    modport slave (
        output start, base_addr, length, readdata, out_ready,
        input  busy, done, address, chipselect, write, byteenable, writedata,
        input  out_data, out_valid
    );
endinterface

// File: rtl/sram_stream_reader.sv
// Reads a block of consecutive SRAM words through the s2 port and streams them out through a
// small FIFO. Reads are throttled so that FIFO occupancy plus the single in-flight read never
// exceeds the FIFO depth, so the one-cycle-latency read data can always be pushed.
module sram_stream_reader #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic               clk,
    input logic               reset,
    sram_stream_reader_if.master bus
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [12:0]           remain_q;
    logic                  in_flight_q;
    logic                  busy_q;
    logic                  done_q;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q;
    logic [PtrW-1:0]       rd_ptr_q;
    logic [CntW-1:0]       cnt_q;
    logic [CntW-1:0]       cnt_d;

    logic issue;
    logic push;
    logic pop;

    // Read issue throttle and FIFO handshake decode.
    always_comb begin
        issue = (state_q == StRead) && (remain_q != 13'd0) &&
                ((32'(cnt_q) + 32'(in_flight_q)) < FIFO_DEPTH);
        push  = in_flight_q;
        pop   = (cnt_q != '0) && bus.out_ready;
        cnt_d = cnt_q + CntW'(push) - CntW'(pop);
    end

    assign bus.address    = addr_q;
    assign bus.chipselect = issue;
    assign bus.write      = 1'b0;
    assign bus.byteenable = 2'b11;
    assign bus.writedata  = '0;
    assign bus.out_valid  = (cnt_q != '0);
    // Forced to zero when empty so the stream reads 0 after reset.
    assign bus.out_data   = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

    // Control FSM, address/remaining counters and FIFO pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remain_q    <= '0;
            in_flight_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            done_q      <= 1'b0;
            in_flight_q <= issue;
            cnt_q       <= cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;

            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        addr_q   <= bus.base_addr;
                        remain_q <= bus.length;
                        busy_q   <= 1'b1;
                        if (bus.length == 13'd0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StRead;
                        end
                    end
                end
                StRead: begin
                    if (issue) begin
                        addr_q   <= addr_q + 1'b1;
                        remain_q <= remain_q - 13'd1;
                        if (remain_q == 13'd1) state_q <= StDrain;
                    end
                end
                StDrain: begin
                    // Finish as the last word pops so done lands the cycle after its handshake.
                    if (cnt_d == '0) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // FIFO storage; read data arrives one cycle after each issued read.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.readdata;
    end
endmodule

// File: tb/tb_sram_stream_reader.sv
// Self-checking bench for sram_stream_reader: table of transfers plus randomized transfers,
// scored against a queue model of the expected word stream, and a mid-transfer reset sequence.
module tb_sram_stream_reader;
    localparam int unsigned AW    = 12;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sram_stream_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sram_stream_reader #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // SRAM s2 model: registered read, one cycle latency.
    logic [DW-1:0] sram [4096];
    always @(posedge clk) begin
        if (bus.chipselect) bus.readdata <= sram[bus.address];
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [11:0] base;
        int          len;
        int          mode;      // 0 ready high, 1 random ready, 2 random with 20-cycle stall
        int          spur;      // pulse a second start while busy
        int          exp_done;  // cycle of done, -1 when sink timing is random
        int          exp_first; // cycle of first word, -1 when not fixed
    } vec_t;

    task automatic run_xfer(input logic [11:0] base, input int len, input int mode,
                            input int spur, input int exp_done, input int exp_first);
        logic [DW-1:0] exp_q[$];
        int            cycle;
        int            issued;
        int            delivered;
        int            first_cyc;
        int            budget;
        bit            stalled;
        bit            seen_done;
        bit            ready;
        logic [DW-1:0] held;
        for (int i = 0; i < len; i++) exp_q.push_back(sram[(int'(base) + i) % 4096]);

        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.length    = 13'(len);
        bus.out_ready = 1'b1;
        #1;
        check("busy_cycle0", 32'(bus.busy), 32'd0);
        check("done_pulse_width", 32'(bus.done), 32'd0);

        cycle = 0; issued = 0; delivered = 0; first_cyc = -1;
        stalled = 1'b0; seen_done = 1'b0; held = '0;
        budget = len * 10 + 100;
        while (!seen_done && cycle < budget) begin
            @(posedge clk); #1;
            cycle++;
            bus.start = 1'b0;
            if (spur != 0 && cycle == 4) begin
                bus.start     = 1'b1;
                bus.base_addr = ~base;
                bus.length    = 13'd5;
            end
            case (mode)
                0:       ready = 1'b1;
                1:       ready = ($urandom_range(0, 3) != 0);
                default: ready = (cycle >= 10 && cycle < 30) ? 1'b0 : ($urandom_range(0, 1) == 1);
            endcase
            bus.out_ready = ready;
            #1;
            if (cycle == 1) check("busy_cycle1", 32'(bus.busy), 32'd1);
            if (stalled) begin
                check("stall_valid", 32'(bus.out_valid), 32'd1);
                check("stall_data", 32'(bus.out_data), 32'(held));
            end
            if (bus.chipselect) begin
                check("rd_addr", 32'(bus.address), 32'((int'(base) + issued) % 4096));
                issued++;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (first_cyc < 0) first_cyc = cycle;
                if (exp_q.size() == 0) check("extra_word", 32'(bus.out_data), 32'hFFFF_FFFF);
                else check("word", 32'(bus.out_data), 32'(exp_q.pop_front()));
                delivered++;
            end
            // Reads issued but not yet delivered can never exceed FIFO capacity.
            n_cmp++;
            if (issued - delivered > int'(DEPTH)) begin
                n_err++;
                $display("FAIL occupancy: got %0d expected <= %0d (t=%0t)",
                         issued - delivered, DEPTH, $time);
            end
            stalled = bus.out_valid && !bus.out_ready;
            held    = bus.out_data;
            if (bus.done) begin
                seen_done = 1'b1;
                check("busy_at_done", 32'(bus.busy), (len == 0) ? 32'd1 : 32'd0);
            end
        end
        bus.out_ready = 1'b1;
        check("done_seen", 32'(seen_done), 32'd1);
        if (exp_done >= 0) check("done_cycle", 32'(cycle), 32'(exp_done));
        if (exp_first >= 0) check("first_word_cycle", 32'(first_cyc), 32'(exp_first));
        check("reads_issued", 32'(issued), 32'(len));
        check("words_left", 32'(exp_q.size()), 32'd0);
    endtask

    vec_t vecs [8];

    initial begin
        int delivered;
        int guard;
        vecs[0] = '{12'h010,    8, 0, 0,   11,  3};
        vecs[1] = '{12'hFFE,    4, 0, 0,    7,  3};
        vecs[2] = '{12'h000,    0, 0, 0,    1, -1};
        vecs[3] = '{12'h050,    1, 0, 0,    4,  3};
        vecs[4] = '{12'h020,   64, 2, 0,   -1, -1};
        vecs[5] = '{12'h100,   16, 0, 1,   19,  3};
        vecs[6] = '{12'h030,   64, 1, 1,   -1, -1};
        vecs[7] = '{12'h123, 4096, 0, 0, 4099,  3};

        for (int i = 0; i < 4096; i++) sram[i] = 16'hA000 + 16'(i);
        bus.start = 1'b0; bus.base_addr = '0; bus.length = '0; bus.out_ready = 1'b0;

        // Reset values
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_cs", 32'(bus.chipselect), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_addr", 32'(bus.address), 32'd0);
        check("rst_data", 32'(bus.out_data), 32'd0);
        check("const_write", 32'(bus.write), 32'd0);
        check("const_be", 32'(bus.byteenable), 32'd3);
        check("const_wdata", 32'(bus.writedata), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Table of transfers, back-to-back (each start lands the cycle after the previous done)
        for (int v = 0; v < 8; v++) begin
            run_xfer(vecs[v].base, vecs[v].len, vecs[v].mode, vecs[v].spur,
                     vecs[v].exp_done, vecs[v].exp_first);
        end

        // Randomized contents, bases and lengths against the queue model
        for (int i = 0; i < 4096; i++) sram[i] = 16'($urandom);
        for (int r = 0; r < 8; r++) begin
            run_xfer(12'($urandom), int'($urandom_range(1, 40)), 1, 0, -1, -1);
        end

        // Reset after 5 of 16 words delivered
        @(posedge clk); #1;
        bus.start = 1'b1; bus.base_addr = 12'h200; bus.length = 13'd16; bus.out_ready = 1'b1;
        delivered = 0; guard = 0;
        while (delivered < 5 && guard < 50) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            guard++;
            #1;
            if (bus.out_valid && bus.out_ready) delivered++;
        end
        check("words_before_reset", 32'(delivered), 32'd5);
        reset = 1'b1;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        check("arst_cs", 32'(bus.chipselect), 32'd0);
        check("arst_valid", 32'(bus.out_valid), 32'd0);
        check("arst_addr", 32'(bus.address), 32'd0);
        check("arst_data", 32'(bus.out_data), 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            check("no_done_in_reset", 32'(bus.done), 32'd0);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        check("no_done_after_reset", 32'(bus.done), 32'd0);
        check("idle_after_reset", 32'(bus.busy), 32'd0);
        run_xfer(12'h200, 16, 0, 0, 19, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sram_stream_reader.md
# sram_stream_reader

Avalon-MM read master for the second (s2) port of the 16-bit × 4096-word on-chip dual-port SRAM, converting a block of SRAM words into a backpressured Avalon-ST word stream. Software or the NPU controller writes tensors into the SRAM through port s1. This block then fetches `length` consecutive words from `base_addr` through s2 and feeds them to downstream compute logic. A small internal FIFO decouples SRAM read latency from sink stalls.

## Interface
- `ADDR_WIDTH`, 12, SRAM word-address width (4096 words)
- `DATA_WIDTH`, 16, SRAM and stream word width
- `FIFO_DEPTH`, 4, output FIFO entries; power of two, ≥2
- `clk`  in  1  single clock for SRAM port and stream
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle command strobe; sampled only in IDLE
- `base_addr`  in  ADDR_WIDTH  first word address, latched on accepted `start`
- `length`  in  13  number of words to read (0..8191), latched on accepted `start`
- `busy`  out  1  high from accepted `start` until `done`
- `done`  out  1  one-cycle pulse when the last word has left the stream port
- `address`  out  ADDR_WIDTH  SRAM s2 address
- `chipselect`  out  1  SRAM s2 read strobe
- `write`  out  1  tied 0
- `byteenable`  out  2  tied 2'b11
- `writedata`  out  DATA_WIDTH  tied 0
- `readdata`  in  DATA_WIDTH  SRAM s2 read data; valid the cycle after `chipselect`
- `out_data`  out  DATA_WIDTH  stream word
- `out_valid`  out  1  stream word valid
- `out_ready`  in  1  sink accepts word when high with `out_valid`

## Operation
- States:
  - IDLE: `start` → READ, latching `base_addr`/`length`. Exception: `length`=0 → DONE.
  - READ: issue reads until `length` reads have been issued → DRAIN.
  - DRAIN: wait until the FIFO is empty and no read is in flight → DONE.
  - DONE: pulse `done` for 1 cycle → IDLE.
- Read issue rule: assert `chipselect` in a READ cycle only when (FIFO occupancy + in-flight reads) < `FIFO_DEPTH`. In-flight reads are 0 or 1, since the fixed SRAM read latency is 1. This guarantees the FIFO never overflows.
- Address counter starts at the latched `base_addr` and increments per issued read, modulo 2^ADDR_WIDTH: 4095 → 0 wrap, no error.
- Remaining-issue counter is 13 bits, decremented per issued read.
- `readdata` is pushed into the FIFO the cycle after each issued read, unconditionally.
- Pop on `out_valid & out_ready`. Push and pop in the same cycle leaves occupancy unchanged.
- `out_data` is the FIFO head and stays stable while `out_valid` is high and `out_ready` is low.
- `start` while `busy` is ignored; latched parameters do not change.
- `write`, `byteenable`, `writedata` are constants; the block never writes the SRAM.
- Reset (asynchronous, any state, mid-transfer included):
  - state → IDLE; FIFO emptied; in-flight read discarded.
  - `busy`, `done`, `chipselect`, `out_valid` = 0; `address`, `out_data` = 0.
  - No `done` is generated for the aborted transfer.

## Timing
- Cycle 0: `start` accepted; `busy` = 1 from cycle 1.
- Cycle 1: first `chipselect` with `address`=`base_addr`.
- Cycle 2: `readdata` captured into the FIFO.
- Cycle 3: first `out_valid`. Start-to-first-word latency is 3 cycles.
- With `out_ready` held high: one read per cycle, one word per cycle, no bubbles after the first word. The last word appears on cycle `length`+2.
- `done` is asserted the cycle after the last word's handshake. `busy` falls in that same cycle.
- `length`=0: `done` on cycle 1, `busy` high during cycle 1 only, no `chipselect`.
- Sink stall: `chipselect` drops within 1 cycle of the FIFO reaching DEPTH−1 occupancy with a read in flight. Issue resumes the cycle after the pop that frees the slot.
- A new `start` is accepted in the cycle after `done`, the earliest possible IDLE cycle.

## Test plan
- Basic block: preload words i ↦ 16'hA000+i. `start` with base=0x010, length=8, `out_ready`=1 → `out_data` 0xA010..0xA017 on cycles 3..10, `done` on cycle 11, exactly 8 `chipselect` cycles.
- Wrap-around: base=0xFFE, length=4 → addresses 0xFFE, 0xFFF, 0x000, 0x001, with stream order matching SRAM contents.
- Backpressure: `out_ready` toggled pseudo-randomly, including an 20-cycle hold low, length=64 → all 64 words in order, none duplicated or lost. `out_data` stable while stalled. Occupancy never exceeds `FIFO_DEPTH`.
- Zero and maximum length:
  - length=0 → `done` at cycle 1, no reads.
  - length=4096 from base=0x123 → every address read exactly once, then `done`.
- Command robustness: `start` pulsed during `busy` with different base/length → ignored, original transfer completes unchanged. Back-to-back `start` on the cycle after `done` is accepted.
- Reset mid-transfer: assert `reset` after 5 of 16 words delivered → all outputs 0 immediately, no `done`. A new transfer after reset delivers correct data from cycle 3.
